piso_serializer: RTL and testbench



---
 rtl/serializer_pkg.sv | 11 +
 rtl/piso_serializer_if.sv | 23 ++
 rtl/piso_serializer_bit_counter.sv | 26 ++
 rtl/piso_serializer.sv | 70 +++++++
 tb/tb_piso_serializer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/serializer_pkg.sv
// Shared types and helpers for the serializer/deserializer pair.
package serializer_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} ser_state_t;

    // Bit-index counter width for a WIDTH-bit frame.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake plus serial-side signals of the PISO transmitter.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             en;
    logic             q;
    logic             q_valid;
    logic             frame_done;
    logic             busy;

    modport master (
        output data_in, load_valid, en,
        input  load_ready, q, q_valid, frame_done, busy
    );

    modport slave (
        input  data_in, load_valid, en,
        output load_ready, q, q_valid, frame_done, busy
    );
endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Up-counter with enable, synchronous clear and terminal-count flag at WIDTH-1.
module bit_counter #(
    parameter int WIDTH = 8,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    assign tc = (cnt == CW'(WIDTH - 1));

    // Clear wins over increment; the count saturates at the terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !tc)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: one word per load, one bit per en strobe.
module piso_serializer
    import serializer_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   LSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    piso_serializer_if.slave   s
);

    localparam int CW = cnt_w(WIDTH);

    ser_state_t       state, state_nxt;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             tc;
    logic             accept;
    logic             advance;

    // en on the accept edge is deliberately ignored so the first bit is always held.
    assign accept  = (state == IDLE)  && s.load_valid;
    assign advance = (state == SHIFT) && s.en;

    bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .inc   (advance),
        .cnt   (cnt),
        .tc    (tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; DONE always lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (s.load_valid)  state_nxt = SHIFT;
            SHIFT:   if (s.en && tc)    state_nxt = DONE;
            DONE:                       state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Shift register: capture on accept, move the next bit into the head on each strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sr <= '0;
        else if (accept)
            sr <= s.data_in;
        else if (advance && !tc)
            sr <= LSB_FIRST ? (sr >> 1) : (sr << 1);
    end

    // Outputs decode registered state only, so reset reaches them without a clock.
    assign s.load_ready = (state == IDLE);
    assign s.q_valid    = (state == SHIFT);
    assign s.frame_done = (state == DONE);
    assign s.busy       = (state == SHIFT) || (state == DONE);
    assign s.q          = (state == SHIFT) ? (LSB_FIRST ? sr[0] : sr[WIDTH-1]) : IDLE_LEVEL;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an LSB-first/idle-0 and an MSB-first/idle-1 instance
// driven with identical stimulus and checked every cycle against a frame-level model.
module tb_piso_serializer;
    import serializer_pkg::*;

    localparam int   W      = 8;
    localparam logic IDLE_A = 1'b0;
    localparam logic IDLE_B = 1'b1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] d = '0;
    logic lv = 1'b0;
    logic en = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(W)) if_a ();
    piso_serializer_if #(.WIDTH(W)) if_b ();

    assign if_a.data_in = d;  assign if_a.load_valid = lv;  assign if_a.en = en;
    assign if_b.data_in = d;  assign if_b.load_valid = lv;  assign if_b.en = en;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(IDLE_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .s(if_a));
    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(IDLE_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .s(if_b));

    // Frame-level model: a word being sent, how many bits consumed, and a done flag.
    bit           m_act;
    bit           m_done;
    logic [W-1:0] m_word;
    int           m_sent;

    task automatic model_reset();
        m_act = 0; m_done = 0; m_word = '0; m_sent = 0;
    endtask

    task automatic model_update();
        if (!rst_n) model_reset();
        else if (m_done) m_done = 0;
        else if (m_act) begin
            if (en) begin
                m_sent++;
                if (m_sent == W) begin m_act = 0; m_done = 1; end
            end
        end else if (lv) begin
            m_act = 1; m_word = d; m_sent = 0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic ea, eb;
        ea = m_act ? m_word[m_sent]     : IDLE_A;
        eb = m_act ? m_word[W-1-m_sent] : IDLE_B;
        chk("a.q",          32'(if_a.q),          32'(ea));
        chk("a.q_valid",    32'(if_a.q_valid),    32'(m_act));
        chk("a.load_ready", 32'(if_a.load_ready), 32'(!m_act && !m_done));
        chk("a.frame_done", 32'(if_a.frame_done), 32'(m_done));
        chk("a.busy",       32'(if_a.busy),       32'(m_act || m_done));
        chk("b.q",          32'(if_b.q),          32'(eb));
        chk("b.q_valid",    32'(if_b.q_valid),    32'(m_act));
        chk("b.load_ready", 32'(if_b.load_ready), 32'(!m_act && !m_done));
        chk("b.frame_done", 32'(if_b.frame_done), 32'(m_done));
        chk("b.busy",       32'(if_b.busy),       32'(m_act || m_done));
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_idle();
        int k;
        lv = 0; en = 0;
        for (k = 0; k < 50 && if_a.load_ready !== 1'b1; k++) step();
        if (k == 50) chk("wait_idle_timeout", 32'(if_a.load_ready), 32'd1);
    endtask

    // Sends one word; en strobes every gap-th SHIFT cycle; records the bits consumed
    // by each strobe (first-sent bit ends up leftmost) and the cycle of frame_done.
    task automatic run_frame(input logic [W-1:0] word, input int gap, input bit noise,
                             output logic [W-1:0] seq_a, output logic [W-1:0] seq_b,
                             output int lat);
        int c;
        wait_idle();
        d = word; lv = 1; en = (gap == 1);
        step();
        lv = 0; seq_a = '0; seq_b = '0; lat = -1;
        for (c = 1; c < 200; c++) begin
            if (if_a.frame_done === 1'b1) begin lat = c; break; end
            en = ((c % gap) == 0);
            if (en && if_a.q_valid === 1'b1) begin
                seq_a = {seq_a[W-2:0], if_a.q};
                seq_b = {seq_b[W-2:0], if_b.q};
            end
            if (noise) begin lv = 1'($urandom); d = W'($urandom); end
            step();
        end
        lv = 0; en = 0;
    endtask

    typedef struct {
        logic [W-1:0] data;
        int           gap;
        bit           noise;
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_b;
        int           exp_lat;
    } vec_t;

    vec_t vt[5];

    initial begin
        logic [W-1:0] sa, sb, ea, eb, dr;
        logic [15:0]  seq16;
        int lat, dones, gp;

        vt[0] = '{8'hA5, 1, 1'b0, 8'b10100101, 8'b10100101, 9};
        vt[1] = '{8'h01, 1, 1'b0, 8'b10000000, 8'b00000001, 9};
        vt[2] = '{8'h3C, 4, 1'b1, 8'b00111100, 8'b00111100, 33};
        vt[3] = '{8'h7E, 2, 1'b0, 8'b01111110, 8'b01111110, 17};
        vt[4] = '{8'h81, 1, 1'b1, 8'b10000001, 8'b10000001, 9};

        // Reset asserted before any clock edge: outputs must already be at reset values.
        model_reset();
        #2;
        check_outputs();
        @(negedge clk);
        rst_n = 1;
        step();
        step();

        for (int i = 0; i < 5; i++) begin
            run_frame(vt[i].data, vt[i].gap, vt[i].noise, sa, sb, lat);
            chk($sformatf("vec%0d.seq_lsb", i), 32'(sa), 32'(vt[i].exp_a));
            chk($sformatf("vec%0d.seq_msb", i), 32'(sb), 32'(vt[i].exp_b));
            chk($sformatf("vec%0d.done_lat", i), 32'(lat), 32'(vt[i].exp_lat));
        end

        // Reset abort after three bits, asynchronous mid-cycle, then a clean frame.
        wait_idle();
        d = 8'hFF; lv = 1; en = 1;
        step();
        lv = 0;
        step(); step(); step();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_outputs();
        step(); step();
        rst_n = 1;
        step();
        run_frame(8'h0F, 1, 1'b0, sa, sb, lat);
        chk("abort.seq_lsb", 32'(sa), 32'(8'b11110000));
        chk("abort.seq_msb", 32'(sb), 32'(8'b00001111));
        chk("abort.done_lat", 32'(lat), 32'd9);

        // Back-to-back with load_valid held high.
        wait_idle();
        d = 8'h81; lv = 1; en = 1;
        step();
        d = 8'h7E; seq16 = '0; dones = 0;
        for (int k = 1; k <= 21; k++) begin
            if (if_a.q_valid === 1'b1) seq16 = {seq16[14:0], if_a.q};
            if (if_a.frame_done === 1'b1) dones++;
            if (k == 10) chk("b2b.ready_at_10", 32'(if_a.load_ready), 32'd1);
            if (k == 11) lv = 0;
            step();
        end
        en = 0;
        chk("b2b.seq", 32'(seq16), 32'(16'b1000000101111110));
        chk("b2b.dones", 32'(dones), 32'd2);

        // Random frames with random gaps, idle strobes and load_valid noise.
        for (int r = 0; r < 40; r++) begin
            wait_idle();
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                en = 1'($urandom);
                step();
            end
            dr = W'($urandom);
            gp = int'($urandom_range(1, 3));
            for (int b = 0; b < W; b++) ea[W-1-b] = dr[b];
            eb = dr;
            run_frame(dr, gp, 1'b1, sa, sb, lat);
            chk("rnd.seq_lsb", 32'(sa), 32'(ea));
            chk("rnd.seq_msb", 32'(sb), 32'(eb));
            chk("rnd.done_lat", 32'(lat), 32'(W * gp + 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
